// File: rtl/ysyx22041405_id_ex_sender.sv
// ID->EX transmit stage: packs IDU decode results into the ID_EX message bus
// and hands it to the EXU through a two-entry skid buffer. The skid entry
// absorbs one extra message while the EXU stalls. The IDU-side ready signal
// comes from a flop, so an EXU stall has no combinational path to the IDU.
// Optional counters: define YSYX22041405_IDEX_PERF_EN to build stall_cnt and
// issue_cnt. Without it both outputs are tied to zero.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The producer keeps its payload stable while valid=1 and ready=0. The
// consumer's ready may depend on anything except the producer's valid in the
// same cycle.
module ysyx22041405_id_ex_sender #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 17,
  parameter int DATA_W = 3*WIDTH+5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_pc,
  input  logic [WIDTH-1:0]         in_imm,
  input  logic [WIDTH-1:0]         in_rdata1,
  input  logic [WIDTH-1:0]         in_rdata2,
  input  logic [4:0]               in_waddr,
  input  logic [13:0]              in_alu_ctrl,
  input  logic                     in_s2_sel,
  input  logic                     in_rf_we,
  input  logic                     in_ebreak,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_pc,
  output logic [CTRL_W+DATA_W-1:0] out_msg,
  output logic                     halted,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              issue_cnt
);

  localparam int MSG_W = CTRL_W + DATA_W;
  // The ebreak flag is the lowest bit of the control field.
  localparam int EBREAK_BIT = DATA_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_pc;
  logic [WIDTH-1:0] skid_pc;
  logic [MSG_W-1:0] main_msg;
  logic [MSG_W-1:0] skid_msg;
  logic             valid_q;
  logic             ready_q;
  logic             halt_q;
  logic [MSG_W-1:0] in_msg;
  logic             in_fire;
  logic             out_fire;
  logic             main_is_ebreak;

  assign in_msg = {in_alu_ctrl, in_s2_sel, in_rf_we, in_ebreak,
                   in_imm, in_rdata1, in_rdata2, in_waddr};

  assign in_fire        = in_valid & ready_q;
  assign out_fire       = valid_q & out_ready;
  assign main_is_ebreak = main_msg[EBREAK_BIT];

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_pc    = main_pc;
  assign out_msg   = main_msg;
  assign halted    = halt_q;

  // Buffer FSM. The valid, ready and halt flops are loaded with the values
  // that belong to the next state, so all three outputs come from flops.
  // ready_q resets to 0 and rises on the first clock edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_EMPTY;
      main_pc  <= '0;
      skid_pc  <= '0;
      main_msg <= '0;
      skid_msg <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
      halt_q   <= 1'b0;
    end else if (state != S_HALT) begin
      if (out_fire && main_is_ebreak) begin
        // A delivered ebreak wins over flush and over any input this cycle.
        state   <= S_HALT;
        valid_q <= 1'b0;
        ready_q <= 1'b0;
        halt_q  <= 1'b1;
      end else if (flush) begin
        state   <= S_EMPTY;
        valid_q <= 1'b0;
        ready_q <= 1'b1;
      end else begin
        case (state)
          S_EMPTY: begin
            ready_q <= 1'b1;
            if (in_fire) begin
              main_pc  <= in_pc;
              main_msg <= in_msg;
              state    <= S_ONE;
              valid_q  <= 1'b1;
            end
          end
          S_ONE: begin
            if (in_fire && out_fire) begin
              main_pc  <= in_pc;
              main_msg <= in_msg;
            end else if (in_fire) begin
              skid_pc  <= in_pc;
              skid_msg <= in_msg;
              state    <= S_TWO;
              ready_q  <= 1'b0;
            end else if (out_fire) begin
              state   <= S_EMPTY;
              valid_q <= 1'b0;
            end
          end
          S_TWO: begin
            if (out_fire) begin
              main_pc  <= skid_pc;
              main_msg <= skid_msg;
              state    <= S_ONE;
              ready_q  <= 1'b1;
            end
          end
          default: begin
            state <= S_HALT;
          end
        endcase
      end
    end
  end

`ifdef YSYX22041405_IDEX_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] issue_q;

  // Performance counters. valid_q is low in HALT, so both counters freeze there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      issue_q <= '0;
    end else begin
      if (valid_q && !out_ready) stall_q <= stall_q + 32'd1;
      if (out_fire)              issue_q <= issue_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign issue_cnt = issue_q;
`else
  assign stall_cnt = 32'd0;
  assign issue_cnt = 32'd0;
`endif

endmodule

// File: doc/ysyx22041405_id_ex_sender.md
Name: ysyx22041405_id_ex_sender

Overview:
- Transmit end of the ID->EX interface: packs IDU decode results into the `ID_EX_message` bus and delivers it to the EXU.
- Two-entry skid buffer with a valid/ready handshake, so an EXU stall never creates a combinational ready path back into the IDU.
- Supports a pipeline flush.
- Enters a sticky halt once an ebreak message has been handed to the EXU.

Parameters:
- WIDTH, 32, datapath width (pc, Imm, register read data).
- CTRL_W, 17, control field width: alu_Ctrl 14 + alu_s2_sel 1 + rf_we 1 + inst_ebreak 1.
- DATA_W, 3*WIDTH+5, data field width: Imm, rf_rdata1, rf_rdata2, rf_waddr.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  IDU has a decoded instruction.
- in_ready  out  1  sender can accept (registered).
- in_pc  in  WIDTH  instruction pc.
- in_imm  in  WIDTH  immediate.
- in_rdata1  in  WIDTH  rs1 data.
- in_rdata2  in  WIDTH  rs2 data.
- in_waddr  in  5  rd index.
- in_alu_ctrl  in  14  ALU one-hot control.
- in_s2_sel  in  1  ALU src2 select (1 = Imm).
- in_rf_we  in  1  register write enable.
- in_ebreak  in  1  instruction is ebreak.
- flush  in  1  discard all buffered messages.
- out_valid  out  1  out_msg/out_pc valid.
- out_ready  in  1  EXU accepts.
- out_pc  out  WIDTH  pc of buffered message.
- out_msg  out  CTRL_W+DATA_W  packed message, MSB->LSB: alu_ctrl, s2_sel, rf_we, ebreak, imm, rdata1, rdata2, waddr.
- halted  out  1  sticky halt after ebreak issue.
- stall_cnt  out  32  cycles with out_valid=1 and out_ready=0.
- issue_cnt  out  32  completed output handshakes.

Behaviour:
- Fire conditions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: main entry (drives out_*) and skid entry. Each holds pc plus the packed message.
- States: EMPTY, ONE (main full), TWO (main+skid full), HALT.
- Outputs by state:
  - out_valid = 1 in ONE/TWO, 0 in EMPTY/HALT.
  - in_ready = 1 in EMPTY/ONE, 0 in TWO/HALT. Decoded from registered state only.
- Transitions (no flush):
  - EMPTY: in_fire -> ONE, main <= input.
  - ONE, in_fire & out_fire -> ONE, main <= input.
  - ONE, in_fire only -> TWO, skid <= input.
  - ONE, out_fire only -> EMPTY.
  - TWO, out_fire -> ONE, main <= skid. No input accepted in TWO.
  - Otherwise hold. Payload is never altered while out_valid=1 and out_ready=0.
- Ebreak halt:
  - An out_fire whose message has ebreak=1 -> HALT next cycle, regardless of in_fire in that cycle.
  - The skid entry and any same-cycle input are discarded.
  - halted=1 from that cycle on; leaves HALT only on rst.
- Flush:
  - flush=1 -> EMPTY next cycle (from ONE/TWO/EMPTY). Overrides in_fire and state updates in that cycle.
  - A concurrent out_fire still counts as delivered, and still triggers HALT if its ebreak=1; HALT beats the flush.
  - flush in HALT has no effect.
- Reset:
  - Asynchronous; applies at any time, including mid-transfer.
  - Goes to EMPTY; all payload registers 0; out_valid=0, in_ready=0 while rst=1, in_ready=1 from the first cycle after deassertion.
  - halted=0, stall_cnt=0, issue_cnt=0.
- Latency: input accepted in cycle N appears on out_* in cycle N+1 when the buffer is empty. Throughput is 1/cycle when out_ready=1.
- Packing: out_msg[CTRL_W+DATA_W-1 -: CTRL_W] is the control field and the low DATA_W bits are the data field; the EXU splits the bus on exactly this boundary.

Optional Feature:
- Macro: YSYX22041405_IDEX_PERF_EN.
- Defined:
  - stall_cnt increments on each cycle with out_valid & ~out_ready.
  - issue_cnt increments on each out_fire.
  - Both are 32-bit, wrap 0xFFFFFFFF->0, are cleared by rst only (not by flush), and freeze in HALT.
- Undefined: both ports present, driven constant 0, no counter flops.

Test Plan:
1. Streaming: reset, out_ready=1; send pc 0x80000000, 0x80000004, 0x80000008 back-to-back -> each on out_pc one cycle after acceptance; in_ready stays 1; issue_cnt=3.
2. Skid: out_ready=0; send A (pc 0x100), then B (pc 0x104) -> state TWO, in_ready=0, out_pc holds 0x100. Raise out_ready -> 0x100 then 0x104 delivered in order; stall_cnt equals the held cycles.
3. Packing: imm=0xFFFFF800, rdata1=0x12345678, rdata2=0, waddr=5, alu_ctrl=14'h0001, s2_sel=1, rf_we=1, ebreak=0 -> out_msg fields match bit-exactly at the documented offsets.
4. Flush in TWO with out_ready=0 and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed messages never appear.
5. Ebreak: deliver message with ebreak=1 while skid holds pc 0x20 -> halted=1 next cycle; out_valid and in_ready stay 0 for 20 cycles despite in_valid=1 and flush pulses; counters frozen.
6. Async reset asserted mid-cycle in TWO -> out_valid=0 and counters 0 immediately, without waiting for a clock edge; normal operation resumes after deassertion.
